// File: rtl/fma16_unpack.sv
// Operand front end for fma16: decodes and classifies three binary16 operands
// and iteratively normalizes subnormals. Define FMA16_UNPACK_DAZ_EN for denormals-are-zero.
module fma16_unpack #(
  parameter int SHIFT_STEP = 1,
  parameter int EXP_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [15:0]      z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             xs,
  output logic             ys,
  output logic             zs,
  output logic [EXP_W-1:0] xe,
  output logic [EXP_W-1:0] ye,
  output logic [EXP_W-1:0] ze_o,
  output logic [10:0]      xm,
  output logic [10:0]      ym,
  output logic [10:0]      zm_o,
  output logic [4:0]       xcls,
  output logic [4:0]       ycls,
  output logic [4:0]       zcls
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Class bit positions: {snan, qnan, inf, sub, zero}
  localparam logic [4:0] CLS_ZERO = 5'b00001;
  localparam logic [4:0] CLS_SUB  = 5'b00010;
  localparam logic [4:0] CLS_INF  = 5'b00100;
  localparam logic [4:0] CLS_QNAN = 5'b01000;
  localparam logic [4:0] CLS_SNAN = 5'b10000;

  logic [1:0]       state_reg;
  logic [15:0]      op_in    [3];
  logic             sign_reg [3];
  logic [EXP_W-1:0] exp_reg  [3];
  logic [10:0]      mant_reg [3];
  logic [4:0]       cls_reg  [3];

  logic [EXP_W-1:0] dec_exp  [3];
  logic [10:0]      dec_mant [3];
  logic [4:0]       dec_cls  [3];
  logic [EXP_W-1:0] exp_next [3];
  logic [10:0]      mant_next[3];
  logic [2:0]       dec_sub;
  logic [2:0]       norm_ok;

  assign op_in[0] = x;
  assign op_in[1] = y;
  assign op_in[2] = z;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_op
      logic [4:0]       fe;
      logic [9:0]       ff;
      logic [EXP_W-1:0] d_exp;
      logic [10:0]      d_mant;
      logic [4:0]       d_cls;
      logic [1:0]       sh;
      logic [10:0]      n_mant;
      logic [EXP_W-1:0] n_exp;

      assign fe = op_in[gi][14:10];
      assign ff = op_in[gi][9:0];

      always_comb begin
        d_exp  = EXP_W'(fe);
        d_mant = {1'b1, ff};
        d_cls  = '0;
        if (fe == 5'd0) begin
          if (ff == 10'd0) begin
            d_exp  = '0;
            d_mant = '0;
            d_cls  = CLS_ZERO;
          end else begin
`ifdef FMA16_UNPACK_DAZ_EN
            d_exp  = '0;
            d_mant = '0;
            d_cls  = CLS_ZERO;
`else
            d_exp  = EXP_W'(1);
            d_mant = {1'b0, ff};
            d_cls  = CLS_SUB;
`endif
          end
        end else if (fe == 5'd31) begin
          if (ff == 10'd0)
            d_cls = CLS_INF;
          else if (ff[9])
            d_cls = CLS_QNAN;
          else
            d_cls = CLS_SNAN;
        end
      end

      // Shift by min(SHIFT_STEP, leading zeros); mant is nonzero for a subnormal.
      always_comb begin
        sh = 2'd0;
        if (cls_reg[gi][1] && !mant_reg[gi][10]) begin
          if (SHIFT_STEP >= 2 && !mant_reg[gi][9])
            sh = 2'd2;
          else
            sh = 2'd1;
        end
        n_mant = mant_reg[gi] << sh;
        n_exp  = exp_reg[gi] - EXP_W'(sh);
      end

      assign dec_exp[gi]   = d_exp;
      assign dec_mant[gi]  = d_mant;
      assign dec_cls[gi]   = d_cls;
      assign dec_sub[gi]   = d_cls[1];
      assign exp_next[gi]  = n_exp;
      assign mant_next[gi] = n_mant;
      assign norm_ok[gi]   = n_mant[10] || !cls_reg[gi][1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        sign_reg[i] <= 1'b0;
        exp_reg[i]  <= '0;
        mant_reg[i] <= '0;
        cls_reg[i]  <= '0;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
              sign_reg[i] <= op_in[i][15];
              exp_reg[i]  <= dec_exp[i];
              mant_reg[i] <= dec_mant[i];
              cls_reg[i]  <= dec_cls[i];
            end
            state_reg <= (|dec_sub) ? S_NORM : S_DONE;
          end
        end
        S_NORM: begin
          for (int i = 0; i < 3; i++) begin
            mant_reg[i] <= mant_next[i];
            exp_reg[i]  <= exp_next[i];
          end
          if (&norm_ok)
            state_reg <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);

  assign xs   = sign_reg[0];
  assign ys   = sign_reg[1];
  assign zs   = sign_reg[2];
  assign xe   = exp_reg[0];
  assign ye   = exp_reg[1];
  assign ze_o = exp_reg[2];
  assign xm   = mant_reg[0];
  assign ym   = mant_reg[1];
  assign zm_o = mant_reg[2];
  assign xcls = cls_reg[0];
  assign ycls = cls_reg[1];
  assign zcls = cls_reg[2];

endmodule

// File: tb/tb_fma16_unpack.sv
// Self-checking bench for fma16_unpack: directed triples, backpressure,
// mid-normalization reset and random operands against a value-level model.
module tb_fma16_unpack;
  localparam int SHIFT_STEP = 1;
  localparam int EXP_W      = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      x, y, z;
  logic             out_valid;
  logic             out_ready;
  logic             xs, ys, zs;
  logic [EXP_W-1:0] xe, ye, ze_o;
  logic [10:0]      xm, ym, zm_o;
  logic [4:0]       xcls, ycls, zcls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fma16_unpack #(.SHIFT_STEP(SHIFT_STEP), .EXP_W(EXP_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z),
    .out_valid(out_valid), .out_ready(out_ready),
    .xs(xs), .ys(ys), .zs(zs),
    .xe(xe), .ye(ye), .ze_o(ze_o),
    .xm(xm), .ym(ym), .zm_o(zm_o),
    .xcls(xcls), .ycls(ycls), .zcls(zcls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value-level decode. A subnormal with leading one at bit p of f
  // needs 10-p left shifts, spread over ceil(shift/SHIFT_STEP) cycles.
  task automatic model(input logic [15:0] v, output logic s, output logic [EXP_W-1:0] e,
                       output logic [10:0] m, output logic [4:0] c, output int nc);
    int ef, f, p, shift;
    ef = int'(v[14:10]);
    f  = int'(v[9:0]);
    s  = v[15];
    nc = 0;
    if (ef == 0 && f == 0) begin
      e = '0; m = '0; c = 5'b00001;
    end else if (ef == 0) begin
`ifdef FMA16_UNPACK_DAZ_EN
      e = '0; m = '0; c = 5'b00001;
`else
      p = 0;
      for (int b = 0; b < 10; b++) if (f >= (1 << b)) p = b;
      shift = 10 - p;
      e  = EXP_W'(1 - shift);
      m  = 11'(f << shift);
      c  = 5'b00010;
      nc = (shift + SHIFT_STEP - 1) / SHIFT_STEP;
`endif
    end else if (ef == 31) begin
      e = EXP_W'(31); m = {1'b1, v[9:0]};
      c = (f == 0) ? 5'b00100 : (v[9] ? 5'b01000 : 5'b10000);
    end else begin
      e = EXP_W'(ef); m = {1'b1, v[9:0]}; c = 5'b00000;
    end
  endtask

  logic             es [3];
  logic [EXP_W-1:0] ee [3];
  logic [10:0]      em [3];
  logic [4:0]       ec [3];
  int               enc[3];
  int               exp_lat;

  task automatic predict(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    model(a, es[0], ee[0], em[0], ec[0], enc[0]);
    model(b, es[1], ee[1], em[1], ec[1], enc[1]);
    model(c, es[2], ee[2], em[2], ec[2], enc[2]);
    exp_lat = 1;
    for (int i = 0; i < 3; i++) if (1 + enc[i] > exp_lat) exp_lat = 1 + enc[i];
  endtask

  task automatic check_fields();
    chk("xs", 32'(xs), 32'(es[0]));  chk("ys", 32'(ys), 32'(es[1]));  chk("zs", 32'(zs), 32'(es[2]));
    chk("xe", 32'(xe), 32'(ee[0]));  chk("ye", 32'(ye), 32'(ee[1]));  chk("ze", 32'(ze_o), 32'(ee[2]));
    chk("xm", 32'(xm), 32'(em[0]));  chk("ym", 32'(ym), 32'(em[1]));  chk("zm", 32'(zm_o), 32'(em[2]));
    chk("xcls", 32'(xcls), 32'(ec[0])); chk("ycls", 32'(ycls), 32'(ec[1])); chk("zcls", 32'(zcls), 32'(ec[2]));
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    x = a; y = b; z = c; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("latency", 32'(cyc + 1), 32'(exp_lat));
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("release", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic run_triple(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    predict(a, b, c);
    accept(a, b, c);
    wait_out();
    check_fields();
    $display("TXN x=%04h y=%04h z=%04h xe=%0d xm=%03h xcls=%05b lat=%0d",
             a, b, c, $signed(xe), xm, xcls, exp_lat);
    release_out();
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 3))
      0: v[14:10] = 5'd0;
      1: v[14:10] = 5'd31;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) v[9:0] = 10'(1 << $urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; z = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_xe", 32'(xe), 32'd0);
    chk("rst_xm", 32'(xm), 32'd0);
    chk("rst_xcls", 32'(xcls), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_triple(16'h3C00, 16'hC000, 16'h0000);
    run_triple(16'h0001, 16'h3C00, 16'h0200);
    run_triple(16'h7C00, 16'h7E00, 16'hFD00);
    run_triple(16'h8001, 16'h03FF, 16'h8000);

    // Backpressure: hold the result, ignore a new in_valid.
    predict(16'h3C00, 16'h3C00, 16'h3C00);
    accept(16'h3C00, 16'h3C00, 16'h3C00);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      x = 16'h4000; y = 16'h0001; z = 16'h7C00;
      @(posedge clk);
      #1;
      chk("bp_valid_ready", {30'd0, out_valid, in_ready}, 32'b10);
      chk("bp_xe", 32'(xe), 32'(ee[0]));
    end
    in_valid = 1'b0;
    check_fields();
    release_out();

    // Reset during the 3rd normalization cycle drops the triple.
    predict(16'h0001, 16'h3C00, 16'h3C00);
    accept(16'h0001, 16'h3C00, 16'h3C00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_valid_ready", {30'd0, out_valid, in_ready}, 32'b01);
    chk("midrst_xe", 32'(xe), 32'd0);
    chk("midrst_xm", 32'(xm), 32'd0);
    chk("midrst_xcls", 32'(xcls), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_triple(16'h3C00, 16'h3C00, 16'h3C00);

    for (int n = 0; n < 25; n++) run_triple(rand_op(), rand_op(), rand_op());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
